// File: rtl/pac_motion.sv
// Pac-Man sprite motion and per-pixel hit stage: steps the sprite once per frame from the keycode.
// Define PAC_WRAP_EN for horizontal tunnel wrap; otherwise every screen edge clamps.
module pac_motion #(
    parameter int SPRITE   = 16,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479,
    parameter int X_START  = 320,
    parameter int Y_START  = 240,
    parameter int STEP     = 1,
    parameter int ANIM_DIV = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       is_pac,
    output logic [9:0] PacX,
    output logic [9:0] PacY,
    output logic [9:0] PacPosX,
    output logic [9:0] PacPosY,
    output logic [1:0] pac_dir,
    output logic       pac_anim
);

    localparam logic [10:0] X_LO   = 11'(X_MIN);
    localparam logic [10:0] X_HI   = 11'(X_MAX - SPRITE + 1);
    localparam logic [10:0] Y_LO   = 11'(Y_MIN);
    localparam logic [10:0] Y_HI   = 11'(Y_MAX - SPRITE + 1);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] SPR_W  = 11'(SPRITE);
    localparam logic [9:0]  STEP_N = 10'(STEP);
    localparam int          CNT_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CNT_W-1:0] ANIM_LAST = CNT_W'(ANIM_DIV - 1);

    typedef enum logic [2:0] {IDLE, MOVE_R, MOVE_L, MOVE_U, MOVE_D} state_t;

    state_t           state_q, state_d;
    logic [9:0]       pos_x_q, pos_y_q;
    logic [9:0]       pos_x_d, pos_y_d;
    logic [1:0]       dir_q, dir_d;
    logic             anim_q;
    logic [CNT_W-1:0] anim_cnt_q;
    logic             frame_clk_q;
    logic             tick;
    logic             hit;
    logic             in_x, in_y;

    assign tick = frame_clk & ~frame_clk_q;

    // Direction from the key is resolved first, then the step is taken in that direction.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (keycode)
            8'h07:   begin state_d = MOVE_R; dir_d = 2'd0; end
            8'h04:   begin state_d = MOVE_L; dir_d = 2'd1; end
            8'h1A:   begin state_d = MOVE_U; dir_d = 2'd2; end
            8'h16:   begin state_d = MOVE_D; dir_d = 2'd3; end
            default: ;
        endcase

        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        hit     = 1'b0;
        case (state_d)
            MOVE_R: begin
                if (({1'b0, pos_x_q} + STEP_W) > X_HI) begin
`ifdef PAC_WRAP_EN
                    pos_x_d = X_LO[9:0];
`else
                    pos_x_d = X_HI[9:0];
                    hit     = 1'b1;
`endif
                end else begin
                    pos_x_d = pos_x_q + STEP_N;
                end
            end
            MOVE_L: begin
                if ({1'b0, pos_x_q} < (X_LO + STEP_W)) begin
`ifdef PAC_WRAP_EN
                    pos_x_d = X_HI[9:0];
`else
                    pos_x_d = X_LO[9:0];
                    hit     = 1'b1;
`endif
                end else begin
                    pos_x_d = pos_x_q - STEP_N;
                end
            end
            MOVE_U: begin
                if ({1'b0, pos_y_q} < (Y_LO + STEP_W)) begin
                    pos_y_d = Y_LO[9:0];
                    hit     = 1'b1;
                end else begin
                    pos_y_d = pos_y_q - STEP_N;
                end
            end
            MOVE_D: begin
                if (({1'b0, pos_y_q} + STEP_W) > Y_HI) begin
                    pos_y_d = Y_HI[9:0];
                    hit     = 1'b1;
                end else begin
                    pos_y_d = pos_y_q + STEP_N;
                end
            end
            default: ;
        endcase
    end

    // Edge detector starts high so a frame_clk already high at release is not a tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            pos_x_q     <= 10'(X_START);
            pos_y_q     <= 10'(Y_START);
            dir_q       <= 2'd0;
            anim_q      <= 1'b0;
            anim_cnt_q  <= '0;
            frame_clk_q <= 1'b1;
        end else begin
            frame_clk_q <= frame_clk;
            if (tick) begin
                dir_q   <= dir_d;
                pos_x_q <= pos_x_d;
                pos_y_q <= pos_y_d;
                state_q <= hit ? IDLE : state_d;
                if ((state_d != IDLE) && !hit) begin
                    if (anim_cnt_q == ANIM_LAST) begin
                        anim_cnt_q <= '0;
                        anim_q     <= ~anim_q;
                    end else begin
                        anim_cnt_q <= anim_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        in_x   = (DrawX >= pos_x_q) && ({1'b0, DrawX} < ({1'b0, pos_x_q} + SPR_W));
        in_y   = (DrawY >= pos_y_q) && ({1'b0, DrawY} < ({1'b0, pos_y_q} + SPR_W));
        is_pac = in_x && in_y;
        PacX   = is_pac ? (DrawX - pos_x_q) : 10'd0;
        PacY   = is_pac ? (DrawY - pos_y_q) : 10'd0;
    end

    assign PacPosX  = pos_x_q;
    assign PacPosY  = pos_y_q;
    assign pac_dir  = dir_q;
    assign pac_anim = anim_q;

endmodule

// File: tb/tb_pac_motion.sv
// Scoreboard bench for pac_motion: stimulus pushes model predictions, a negedge monitor checks them.
module tb_pac_motion;

    localparam int SPRITE   = 16;
    localparam int XHI      = 639 - SPRITE + 1;
    localparam int YHI      = 479 - SPRITE + 1;
    localparam int ANIM_DIV = 8;
    localparam int STEP     = 1;
`ifdef PAC_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic       is_pac;
    logic [9:0] PacX, PacY, PacPosX, PacPosY;
    logic [1:0] pac_dir;
    logic       pac_anim;

    pac_motion dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .DrawX(DrawX), .DrawY(DrawY), .is_pac(is_pac), .PacX(PacX), .PacY(PacY),
        .PacPosX(PacPosX), .PacPosY(PacPosY), .pac_dir(pac_dir), .pac_anim(pac_anim)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        bit pix;
        int a, b, c, d;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;

    // Reference model: position in plain integers, moving direction -1 when stopped.
    int mx, my, mdir, mmove, manim, mcnt;

    task automatic model_reset();
        mx = 320; my = 240; mdir = 0; mmove = -1; manim = 0; mcnt = 0;
    endtask

    task automatic model_tick(input logic [7:0] key);
        int kd, nx, ny;
        bit blocked;
        kd = (key == 8'h07) ? 0 : (key == 8'h04) ? 1 : (key == 8'h1A) ? 2 : (key == 8'h16) ? 3 : -1;
        if (kd >= 0) begin
            mdir = kd;
            mmove = kd;
        end
        if (mmove >= 0) begin
            nx = mx; ny = my; blocked = 1'b0;
            case (mmove)
                0: nx = mx + STEP;
                1: nx = mx - STEP;
                2: ny = my - STEP;
                default: ny = my + STEP;
            endcase
            if (nx > XHI) begin
                if (WRAP) nx = 0;
                else begin nx = XHI; blocked = 1'b1; end
            end
            if (nx < 0) begin
                if (WRAP) nx = XHI;
                else begin nx = 0; blocked = 1'b1; end
            end
            if (ny < 0)   begin ny = 0;   blocked = 1'b1; end
            if (ny > YHI) begin ny = YHI; blocked = 1'b1; end
            mx = nx; my = ny;
            if (blocked) mmove = -1;
            else begin
                mcnt++;
                if (mcnt == ANIM_DIV) begin
                    mcnt = 0;
                    manim ^= 1;
                end
            end
        end
    endtask

    task automatic push_state(input int due);
        exp_t e;
        e.due = due; e.pix = 1'b0; e.a = mx; e.b = my; e.c = mdir; e.d = manim;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input int req);
        n_chk++;
        if (act !== 32'(req)) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, req);
        end
    endtask

    always @(negedge Clk) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.pix) begin
                chk("is_pac", 32'(is_pac), e.a);
                chk("PacX", 32'(PacX), e.b);
                chk("PacY", 32'(PacY), e.c);
            end else begin
                chk("PacPosX", 32'(PacPosX), e.a);
                chk("PacPosY", 32'(PacPosY), e.b);
                chk("pac_dir", 32'(pac_dir), e.c);
                chk("pac_anim", 32'(pac_anim), e.d);
            end
        end
    end

    task automatic do_reset();
        @(posedge Clk); #1;
        Reset = 1'b1;
        model_reset();
        push_state(cyc);
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        push_state(cyc);
    endtask

    task automatic frame_edge(input logic [7:0] key);
        @(posedge Clk); #1;
        keycode = key;
        frame_clk = 1'b1;
        model_tick(key);
        push_state(cyc + 1);
        @(posedge Clk); #1;
        @(posedge Clk); #1 frame_clk = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic pix(input int x, input int y);
        exp_t e;
        bit inb;
        @(posedge Clk); #1;
        DrawX = 10'(x);
        DrawY = 10'(y);
        inb = (x >= mx) && (x <= mx + SPRITE - 1) && (y >= my) && (y <= my + SPRITE - 1);
        e.due = cyc; e.pix = 1'b1; e.a = int'(inb);
        e.b = inb ? x - mx : 0; e.c = inb ? y - my : 0; e.d = 0;
        q.push_back(e);
    endtask

    task automatic pix_near();
        int x, y;
        x = mx + int'($urandom_range(0, 19)) - 2;
        y = my + int'($urandom_range(0, 19)) - 2;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        pix(x, y);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] keys[8] = '{8'h07, 8'h04, 8'h1A, 8'h16, 8'h00, 8'h55, 8'hFF, 8'h1A};

    initial begin : stim
        logic [7:0] k;
        int run;
        model_reset();
        do_reset();
        pix(325, 245); pix(336, 245); pix(320, 240); pix(335, 255);
        pix(319, 240); pix(320, 256);

        repeat (10) frame_edge(8'h07);
        pix(331, 241);
        repeat (3) frame_edge(8'h1A);
        repeat (4) frame_edge(8'h00);
        repeat (3) frame_edge(8'h16);
        pix_near();

        do_reset();
        repeat (315) frame_edge(8'h07);
        pix(630, 245);

        do_reset();
        repeat (321) frame_edge(8'h04);
        pix(5, 245);
        repeat (250) frame_edge(8'h1A);
        repeat (3) frame_edge(8'h16);
        repeat (3) frame_edge(8'h04);
        pix_near();

        do_reset();
        repeat (5) frame_edge(8'h07);
        @(posedge Clk); #1;
        keycode = 8'h07;
        frame_clk = 1'b1;
        model_tick(8'h07);
        push_state(cyc + 1);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b1;
        model_reset();
        push_state(cyc);
        @(posedge Clk); #1 Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1 push_state(cyc);
        frame_clk = 1'b0;
        @(posedge Clk); #1;
        frame_edge(8'h07);

        do_reset();
        for (int i = 0; i < 40; i++) begin
            k = keys[$urandom_range(0, 7)];
            run = int'($urandom_range(1, 40));
            for (int j = 0; j < run; j++) frame_edge(k);
            pix_near();
        end

        repeat (3) @(posedge Clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
